shiftadd_fold_unit: RTL

//   Serial shift-add folding core that answers the start/valid request of the serial reduction top.
//   One request performs one pseudo-Mersenne fold of x for m = 2^k - c (k = bit length of m):
//   x = hi*2^k + lo  ->  lo + hi*c, followed by one conditional subtraction of m.
//   hi*c is formed serially, one bit of c per cycle. The top re-issues requests until result < m.

---
 rtl/shiftadd_fold_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/shiftadd_fold_unit.sv
// Serial pseudo-Mersenne fold: x = hi*2^k + lo -> lo + hi*c (c = 2^k - m), then one
// conditional subtraction of m. hi*c is accumulated one bit of c per cycle.
module shiftadd_fold_unit #(
  parameter int DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {IDLE, MUL, SUB, DONE} state_e;

  localparam logic [6:0] K_MIN = 7'd2;
  localparam logic [6:0] K_MAX = 7'(DATA_LENGTH - 1);

  state_e state_q, state_d;

  logic [DATA_LENGTH-1:0] hi_r, c_r, acc_r, m_r;
  logic [DATA_LENGTH-1:0] hi_n, lo_n, c_n, pow_k, mask_k;
  logic [6:0]             k_w;
  logic                   k_ok, accept, mul_done;
  logic                   unused_bl;

  function automatic logic [DATA_LENGTH-1:0] cond_sub(
    input logic [DATA_LENGTH-1:0] a,
    input logic [DATA_LENGTH-1:0] m
  );
    return (a >= m) ? (a - m) : a;
  endfunction

  assign unused_bl = ^m_bl_i[DATA_LENGTH-1:7];
  assign k_w       = m_bl_i[6:0];
  assign k_ok      = (k_w >= K_MIN) && (k_w <= K_MAX);
  assign pow_k     = DATA_LENGTH'(1) << k_w;
  assign mask_k    = pow_k - DATA_LENGTH'(1);
  assign accept    = (state_q == IDLE) && start_i;
  assign mul_done  = (hi_r == '0) || (c_r == '0);

  // Operand split; an out-of-range k degenerates to a plain conditional subtraction.
  always_comb begin
    hi_n = '0;
    lo_n = x_i;
    c_n  = '0;
    if (k_ok) begin
      hi_n = x_i >> k_w;
      lo_n = x_i & mask_k;
      c_n  = (pow_k - m_i) & mask_k;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = MUL;
      MUL:     if (mul_done) state_d = SUB;
      SUB:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == DONE);
    busy_o  = (state_q != IDLE);
  end

  // Datapath: load on accept, shift-add while c has bits left, reduce once in SUB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_r     <= '0;
      c_r      <= '0;
      acc_r    <= '0;
      m_r      <= '0;
      result_o <= '0;
    end else if (accept) begin
      hi_r  <= hi_n;
      c_r   <= c_n;
      acc_r <= lo_n;
      m_r   <= m_i;
    end else if ((state_q == MUL) && !mul_done) begin
      if (c_r[0]) acc_r <= acc_r + hi_r;
      hi_r <= hi_r << 1;
      c_r  <= c_r >> 1;
    end else if (state_q == SUB) begin
      result_o <= cond_sub(acc_r, m_r);
    end
  end

endmodule
